// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection,
//               bubble insertion, branch flush and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic [1:0]        id_ALUOp,
  input  logic              flush,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic [1:0]        ex_ALUOp,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic w_src_match;
  logic w_hz;
  logic w_kill;
  logic w_ctrl_en;

  // Both source indices are compared for every format; false stalls on
  // formats without rs2 are accepted in exchange for a simpler detector.
  assign w_src_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign w_hz        = ex_valid && ex_MemRead && (ex_rd != 5'd0) &&
                       id_valid && w_src_match;
  assign stall       = w_hz && !flush;
  assign w_kill      = flush || w_hz;
  assign w_ctrl_en   = !w_kill && id_valid;

  // Data and index fields always follow decode; a bubble keeps them harmlessly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
    end else begin
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
    end
  end

  // Control is zeroed for flushes, bubbles and non-valid decode slots so a
  // dead EX slot can never write memory or the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_ALUOp    <= 2'b00;
    end else begin
      ex_valid    <= !w_kill && id_valid;
      ex_ALUSrc   <= w_ctrl_en && id_ALUSrc;
      ex_MemtoReg <= w_ctrl_en && id_MemtoReg;
      ex_RegWrite <= w_ctrl_en && id_RegWrite;
      ex_MemRead  <= w_ctrl_en && id_MemRead;
      ex_MemWrite <= w_ctrl_en && id_MemWrite;
      ex_Branch   <= w_ctrl_en && id_Branch;
      ex_ALUOp    <= w_ctrl_en ? id_ALUOp : 2'b00;
    end
  end

  // Only hazard bubbles are counted; flushes win over hazards and are not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (stall && (bubble_cnt != c_cnt_max)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Testbench for id_ex_stage: reference model plus per-cycle compare and
// directed load-use, flush, reset and saturation scenarios.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 9;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic [7:0]        id_ctrl;  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
  logic              flush;

  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic              ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
  logic              ex_MemWrite, ex_Branch;
  logic [1:0]        ex_ALUOp;
  logic              stall;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_ALUSrc(id_ctrl[7]), .id_MemtoReg(id_ctrl[6]), .id_RegWrite(id_ctrl[5]),
    .id_MemRead(id_ctrl[4]), .id_MemWrite(id_ctrl[3]), .id_Branch(id_ctrl[2]),
    .id_ALUOp(id_ctrl[1:0]), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  logic              m_valid;
  logic [7:0]        m_ctrl;
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [2:0]        m_f3;
  logic [6:0]        m_f7;
  int                m_cnt;

  function automatic logic model_hz();
    return m_valid && m_ctrl[4] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_ctrl = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_cnt = 0;
    end else begin
      logic hz;
      hz = model_hz();
      if (flush || hz) begin
        m_valid = 0;
        m_ctrl  = 0;
        if (!flush && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else begin
        m_valid = id_valid;
        m_ctrl  = id_valid ? id_ctrl : 8'h00;
      end
      m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_ctrl", {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                         ex_MemWrite, ex_Branch, ex_ALUOp}, {m_valid, m_ctrl});
    check("model_data", {ex_pc, ex_rd1, ex_rd2, ex_imm}, {m_pc, m_rd1, m_rd2, m_imm});
    check("model_idx", {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7},
          {m_rs1, m_rs2, m_rd, m_f3, m_f7});
    check("model_stall", stall, reset ? 1'b0 : (model_hz() && !flush));
    check("model_cnt", bubble_cnt, m_cnt[CNT_W-1:0]);
  end

  task automatic drv(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic [7:0] ctrl, input logic fl);
    id_valid = v; id_pc = pc; id_rd1 = a; id_rd2 = b; id_imm = a ^ 32'h0000_0F0F;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_funct3 = pc[2:0]; id_funct7 = {2'b00, d};
    id_ctrl = ctrl; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [7:0] C_LW  = 8'b1110_0000 | 8'b0001_0000; // ALUSrc,MemtoReg,RegWrite,MemRead, ALUOp=00
  localparam logic [7:0] C_ADD = 8'b0010_0010;               // RegWrite, ALUOp=10

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    step(); step();
    reset = 0;
    #1;
    check("rst_valid", ex_valid, 1'b0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_stall", stall, 1'b0);

    // add x3,x1,x2 pass-through
    drv(1, 9'h004, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, C_ADD, 0);
    #1 check("pass_stall_pre", stall, 1'b0);
    step();
    check("pass_fields", {ex_valid, ex_rd1, ex_rd2, ex_rs1, ex_rs2, ex_rd, ex_ALUOp, ex_RegWrite},
          {1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 2'b10, 1'b1});

    // lw x5 then add x6,x5,x1
    drv(1, 9'h008, 32'd100, 32'd0, 5'd1, 5'd0, 5'd5, C_LW, 0);
    step();
    drv(1, 9'h00C, 32'd9, 32'd4, 5'd5, 5'd1, 5'd6, C_ADD, 0);
    #1 check("lu_stall", stall, 1'b1);
    step();
    check("lu_bubble", {ex_valid, ex_RegWrite, ex_MemRead, ex_ALUOp}, 5'b0);
    check("lu_cnt", bubble_cnt, 2'd1);
    check("lu_stall_drop", stall, 1'b0);
    step();
    check("lu_enter", {ex_valid, ex_rd, ex_pc}, {1'b1, 5'd6, 9'h00C});

    // lw x0 followed by a use of x0
    drv(1, 9'h010, 0, 0, 5'd1, 5'd0, 5'd0, C_LW, 0);
    step();
    drv(1, 9'h014, 0, 0, 5'd0, 5'd0, 5'd7, C_ADD, 0);
    #1 check("x0_nostall", stall, 1'b0);
    // lw x5 followed by an instruction using x6,x7
    drv(1, 9'h018, 0, 0, 5'd1, 5'd0, 5'd5, C_LW, 0);
    step();
    drv(1, 9'h01C, 0, 0, 5'd6, 5'd7, 5'd8, C_ADD, 0);
    #1 check("nomatch_nostall", stall, 1'b0);
    // non-valid load in EX with matching rd
    drv(0, 9'h020, 0, 0, 5'd1, 5'd0, 5'd5, C_LW, 0);
    step();
    check("inv_ctrl", {ex_valid, ex_MemRead, ex_RegWrite}, 3'b000);
    drv(1, 9'h024, 0, 0, 5'd5, 5'd5, 5'd9, C_ADD, 0);
    #1 check("inv_nostall", stall, 1'b0);

    // hazard and flush together
    drv(1, 9'h028, 0, 0, 5'd1, 5'd0, 5'd5, C_LW, 0);
    step();
    drv(1, 9'h02C, 0, 0, 5'd5, 5'd1, 5'd6, C_ADD, 1);
    #1 check("fl_stall", stall, 1'b0);
    step();
    check("fl_kill", {ex_valid, ex_RegWrite, ex_ALUOp}, 4'b0);
    check("fl_cnt", bubble_cnt, 2'd1);

    // reset during a stall
    drv(1, 9'h030, 0, 0, 5'd1, 5'd0, 5'd5, C_LW, 0);
    step();
    drv(1, 9'h034, 0, 0, 5'd2, 5'd5, 5'd6, C_ADD, 0);
    #1 check("ms_stall", stall, 1'b1);
    #1 reset = 1;
    #1 check("ms_rst", {stall, ex_valid, ex_MemRead, bubble_cnt}, 5'b0);
    step();
    reset = 0;

    // five bubbles against a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      drv(1, 9'(9'h040 + 8 * i), 32'(i), 0, 5'd1, 5'd0, 5'd5, C_LW, 0);
      step();
      drv(1, 9'(9'h044 + 8 * i), 0, 0, 5'd5, 5'd3, 5'd6, C_ADD, 0);
      step();
      check("sat_cnt", bubble_cnt, exp_cnt);
    end

    // asynchronous reset between edges
    drv(1, 9'h010, 32'hDEADBEEF, 0, 5'd1, 5'd2, 5'd3, 8'b0010_0000, 0);
    step();
    check("mid_load", {ex_pc, ex_rd1, ex_RegWrite}, {9'h010, 32'hDEADBEEF, 1'b1});
    #1 reset = 1;
    #1 check("mid_rst", {ex_valid, ex_pc, ex_rd1, ex_RegWrite, ex_rd, bubble_cnt, stall}, 0);
    step();
    reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
